// File: rtl/mem_request_issuer.sv
// Packs pipeline memory ops into load/store FIFO words and allocates a source tag per request.
// Latency: accept at edge N, FIFO write strobe during cycle N+1 when the target FIFO is not full.
// Backpressure: target FIFO full holds the word in place and drops req_ready until the strobe fires.
module mem_request_issuer #(
    parameter int ADDR_WIDTH             = 12,
    parameter int DATA_WIDTH             = 32,
    parameter int TAG_WIDTH              = 4,
    parameter int load_fifo_word_length  = 22,
    parameter int store_fifo_word_length = 54
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_is_store,
    input  logic [ADDR_WIDTH-1:0]             req_addr,
    input  logic [DATA_WIDTH-1:0]             req_data,
    input  logic [1:0]                        req_size,
    output logic                              load_fifo_write_signal,
    output logic [load_fifo_word_length-1:0]  load_fifo_write_data,
    input  logic                              load_fifo_full_signal,
    output logic                              store_fifo_write_signal,
    output logic [store_fifo_word_length-1:0] store_fifo_write_data,
    input  logic                              store_fifo_full_signal,
    input  logic                              retire_valid,
    input  logic [TAG_WIDTH-1:0]              retire_tag,
    output logic [TAG_WIDTH:0]                outstanding_count,
    output logic                              misaligned_error
);
    localparam int NTAGS = 1 << TAG_WIDTH;

    typedef enum logic {IDLE, PEND} state_t;

    state_t                            state;
    logic [NTAGS-1:0]                  busy;
    logic                              hold_store;
    logic [store_fifo_word_length-1:0] hold_word;

    logic [3:0]                        mask;
    logic                              aligned;
    logic [DATA_WIDTH-1:0]             lane_data;
    logic [TAG_WIDTH-1:0]              free_tag;
    logic                              have_free;
    logic                              strobe;
    logic                              accept;
    logic                              alloc;
    logic [NTAGS-1:0]                  retire_mask;
    logic [NTAGS-1:0]                  alloc_mask;
    logic [load_fifo_word_length-1:0]  load_word;
    logic [store_fifo_word_length-1:0] store_word;

    always_comb begin
        mask    = 4'b0000;
        aligned = 1'b0;
        case (req_size)
            2'd0: begin
                mask    = 4'b0001 << req_addr[1:0];
                aligned = 1'b1;
            end
            2'd1: begin
                mask    = req_addr[1] ? 4'b1100 : 4'b0011;
                aligned = !req_addr[0];
            end
            2'd2: begin
                mask    = 4'b1111;
                aligned = (req_addr[1:0] == 2'b00);
            end
            default: begin
                mask    = 4'b0000;
                aligned = 1'b0;
            end
        endcase
    end

    assign lane_data = req_data << {req_addr[1:0], 3'b000};

    // Descending scan so the last hit is the lowest free index.
    always_comb begin
        free_tag  = '0;
        have_free = 1'b0;
        for (int i = NTAGS - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_tag  = TAG_WIDTH'(i);
                have_free = 1'b1;
            end
        end
    end

    always_comb begin
        outstanding_count = '0;
        for (int i = 0; i < NTAGS; i++) begin
            outstanding_count = outstanding_count + (TAG_WIDTH + 1)'(busy[i]);
        end
    end

    assign strobe    = (state == PEND) &&
                       !(hold_store ? store_fifo_full_signal : load_fifo_full_signal);
    assign req_ready = have_free && ((state == IDLE) || strobe);
    assign accept    = req_valid && req_ready;
    assign alloc     = accept && aligned;

    assign load_word  = {req_addr, mask, free_tag, req_size};
    assign store_word = {req_addr, lane_data, mask, free_tag, req_size};

    // Allocation sees the pre-edge bitmap, so a same-cycle retire of the new tag is a no-op.
    assign retire_mask = retire_valid ? (NTAGS'(1) << retire_tag) : '0;
    assign alloc_mask  = alloc ? (NTAGS'(1) << free_tag) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            busy             <= '0;
            hold_store       <= 1'b0;
            hold_word        <= '0;
            misaligned_error <= 1'b0;
        end else begin
            busy             <= (busy & ~retire_mask) | alloc_mask;
            misaligned_error <= accept && !aligned;
            if (alloc) begin
                state      <= PEND;
                hold_store <= req_is_store;
                hold_word  <= req_is_store ? store_word
                                           : {{(store_fifo_word_length - load_fifo_word_length){1'b0}}, load_word};
            end else if (strobe) begin
                state <= IDLE;
            end
        end
    end

    assign load_fifo_write_signal  = strobe && !hold_store;
    assign store_fifo_write_signal = strobe && hold_store;
    assign load_fifo_write_data    = (state == PEND && !hold_store) ? hold_word[load_fifo_word_length-1:0] : '0;
    assign store_fifo_write_data   = (state == PEND && hold_store) ? hold_word : '0;

endmodule

// File: tb/tb_mem_request_issuer.sv
// Bench for mem_request_issuer: directed vector table, hand sequences, and random traffic against a reference model.
module tb_mem_request_issuer;
    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [11:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        load_fifo_write_signal;
    logic [21:0] load_fifo_write_data;
    logic        load_fifo_full_signal;
    logic        store_fifo_write_signal;
    logic [53:0] store_fifo_write_data;
    logic        store_fifo_full_signal;
    logic        retire_valid;
    logic [3:0]  retire_tag;
    logic [4:0]  outstanding_count;
    logic        misaligned_error;

    mem_request_issuer dut (
        .clk                     (clk),
        .reset                   (reset),
        .req_valid               (req_valid),
        .req_ready               (req_ready),
        .req_is_store            (req_is_store),
        .req_addr                (req_addr),
        .req_data                (req_data),
        .req_size                (req_size),
        .load_fifo_write_signal  (load_fifo_write_signal),
        .load_fifo_write_data    (load_fifo_write_data),
        .load_fifo_full_signal   (load_fifo_full_signal),
        .store_fifo_write_signal (store_fifo_write_signal),
        .store_fifo_write_data   (store_fifo_write_data),
        .store_fifo_full_signal  (store_fifo_full_signal),
        .retire_valid            (retire_valid),
        .retire_tag              (retire_tag),
        .outstanding_count       (outstanding_count),
        .misaligned_error        (misaligned_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    // Reference model: busy set, one pending word, misaligned flag.
    bit          m_busy[16];
    bit          m_pend;
    bit          m_pst;
    longint      m_word;
    bit          m_mis;
    bit          e_lstb, e_sstb, e_rdy;
    longint      e_ldat, e_sdat;
    int          e_cnt;

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 0;
        m_pend = 0; m_pst = 0; m_word = 0; m_mis = 0;
    endtask

    task automatic model_eval();
        e_cnt = 0;
        foreach (m_busy[i]) e_cnt += m_busy[i];
        e_lstb = m_pend && !m_pst && !load_fifo_full_signal;
        e_sstb = m_pend && m_pst && !store_fifo_full_signal;
        e_rdy  = (e_cnt < 16) && (!m_pend || e_lstb || e_sstb);
        e_ldat = (m_pend && !m_pst) ? m_word : 0;
        e_sdat = (m_pend && m_pst) ? m_word : 0;
    endtask

    task automatic model_next();
        int     off, sz, msk, tag;
        bit     acc, al;
        longint lane;
        model_eval();
        off = int'(req_addr) % 4;
        sz  = int'(req_size);
        acc = req_valid && e_rdy;
        al  = (sz == 0) || (sz == 1 && off % 2 == 0) || (sz == 2 && off == 0);
        msk = (sz == 0) ? (1 << off) : (sz == 1) ? ((off >= 2) ? 12 : 3) : 15;
        tag = -1;
        for (int i = 15; i >= 0; i--) if (!m_busy[i]) tag = i;
        lane = (longint'(req_data) << (8 * off)) & 64'hFFFF_FFFF;
        if (retire_valid) m_busy[retire_tag] = 0;
        m_mis = acc && !al;
        if (acc && al) begin
            m_busy[tag] = 1;
            m_pend = 1;
            m_pst  = req_is_store;
            if (req_is_store)
                m_word = longint'(req_addr) * (64'd1 << 42) + lane * 1024 + msk * 64 + tag * 4 + sz;
            else
                m_word = longint'(req_addr) * 1024 + msk * 64 + tag * 4 + sz;
        end else if (e_lstb || e_sstb) begin
            m_pend = 0;
        end
    endtask

    task automatic check_model();
        model_eval();
        chk("m_lstb",  64'(load_fifo_write_signal),  64'(e_lstb));
        chk("m_ldat",  64'(load_fifo_write_data),    e_ldat);
        chk("m_sstb",  64'(store_fifo_write_signal), 64'(e_sstb));
        chk("m_sdat",  64'(store_fifo_write_data),   e_sdat);
        chk("m_ready", 64'(req_ready),               64'(e_rdy));
        chk("m_count", 64'(outstanding_count),       64'(e_cnt));
        chk("m_mis",   64'(misaligned_error),        64'(m_mis));
    endtask

    task automatic drive(input bit v, input bit st, input logic [11:0] a, input logic [31:0] d,
                         input logic [1:0] s, input bit lf, input bit sf, input bit rv, input logic [3:0] rt);
        req_valid = v; req_is_store = st; req_addr = a; req_data = d; req_size = s;
        load_fifo_full_signal = lf; store_fifo_full_signal = sf; retire_valid = rv; retire_tag = rt;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic advance();
        model_next();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit          v, st;
        logic [11:0] a;
        logic [31:0] d;
        logic [1:0]  s;
        bit          lf, sf, rv;
        logic [3:0]  rt;
        bit          lstb;
        logic [21:0] ldat;
        bit          sstb;
        logic [53:0] sdat;
        bit          rdy;
        logic [4:0]  cnt;
        bit          mis;
    } vec_t;

    function automatic vec_t mk(bit v, bit st, logic [11:0] a, logic [31:0] d, logic [1:0] s,
                                bit lf, bit sf, bit rv, logic [3:0] rt, bit lstb, logic [21:0] ldat,
                                bit sstb, logic [53:0] sdat, bit rdy, logic [4:0] cnt, bit mis);
        vec_t r;
        r.v = v; r.st = st; r.a = a; r.d = d; r.s = s; r.lf = lf; r.sf = sf; r.rv = rv; r.rt = rt;
        r.lstb = lstb; r.ldat = ldat; r.sstb = sstb; r.sdat = sdat; r.rdy = rdy; r.cnt = cnt; r.mis = mis;
        return r;
    endfunction

    initial begin
        vec_t        tbl[17];
        logic [21:0] w1, w9;
        logic [53:0] w3, w5;
        w1 = {12'h010, 4'b1111, 4'd0, 2'd2};
        w3 = {12'h003, 32'hAB00_0000, 4'b1000, 4'd0, 2'd0};
        w5 = {12'h100, 32'h1234_5678, 4'b1111, 4'd0, 2'd2};
        w9 = {12'h020, 4'b0011, 4'd1, 2'd1};
        //            v  st addr    data          sz lf sf rv rt    lstb ldat sstb sdat rdy cnt mis
        tbl[0]  = mk(0, 0, 12'h000, 32'h0,        0, 0, 0, 0, 4'd0, 0, 0,  0, 0,  1, 0, 0);
        tbl[1]  = mk(1, 0, 12'h010, 32'h0,        2, 0, 0, 0, 4'd0, 0, 0,  0, 0,  1, 0, 0);
        tbl[2]  = mk(0, 0, 12'h000, 32'h0,        0, 0, 0, 1, 4'd0, 1, w1, 0, 0,  1, 1, 0);
        tbl[3]  = mk(1, 1, 12'h003, 32'hAB,       0, 0, 0, 0, 4'd0, 0, 0,  0, 0,  1, 0, 0);
        tbl[4]  = mk(0, 0, 12'h000, 32'h0,        0, 0, 0, 1, 4'd0, 0, 0,  1, w3, 1, 1, 0);
        tbl[5]  = mk(1, 1, 12'h100, 32'h12345678, 2, 0, 1, 0, 4'd0, 0, 0,  0, 0,  1, 0, 0);
        tbl[6]  = mk(1, 0, 12'h020, 32'h0,        1, 0, 1, 0, 4'd0, 0, 0,  0, w5, 0, 1, 0);
        tbl[7]  = mk(1, 0, 12'h020, 32'h0,        1, 0, 1, 0, 4'd0, 0, 0,  0, w5, 0, 1, 0);
        tbl[8]  = mk(1, 0, 12'h020, 32'h0,        1, 0, 1, 0, 4'd0, 0, 0,  0, w5, 0, 1, 0);
        tbl[9]  = mk(1, 0, 12'h020, 32'h0,        1, 0, 0, 0, 4'd0, 0, 0,  1, w5, 1, 1, 0);
        tbl[10] = mk(0, 0, 12'h000, 32'h0,        0, 0, 0, 1, 4'd0, 1, w9, 0, 0,  1, 2, 0);
        tbl[11] = mk(0, 0, 12'h000, 32'h0,        0, 0, 0, 1, 4'd1, 0, 0,  0, 0,  1, 1, 0);
        tbl[12] = mk(1, 0, 12'h001, 32'h0,        1, 0, 0, 0, 4'd0, 0, 0,  0, 0,  1, 0, 0);
        tbl[13] = mk(0, 0, 12'h000, 32'h0,        0, 0, 0, 0, 4'd0, 0, 0,  0, 0,  1, 0, 1);
        tbl[14] = mk(1, 1, 12'h100, 32'h5,        3, 0, 0, 0, 4'd0, 0, 0,  0, 0,  1, 0, 0);
        tbl[15] = mk(0, 0, 12'h000, 32'h0,        0, 0, 0, 0, 4'd0, 0, 0,  0, 0,  1, 0, 1);
        tbl[16] = mk(0, 0, 12'h000, 32'h0,        0, 0, 0, 0, 4'd0, 0, 0,  0, 0,  1, 0, 0);

        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_lstb",  64'(load_fifo_write_signal),  0);
        chk("rst_sstb",  64'(store_fifo_write_signal), 0);
        chk("rst_ldat",  64'(load_fifo_write_data),    0);
        chk("rst_sdat",  64'(store_fifo_write_data),   0);
        chk("rst_count", 64'(outstanding_count),       0);
        chk("rst_mis",   64'(misaligned_error),        0);
        reset = 1'b1;

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].v, tbl[i].st, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].lf, tbl[i].sf, tbl[i].rv, tbl[i].rt);
            settle();
            chk($sformatf("v%0d_lstb", i),  64'(load_fifo_write_signal),  64'(tbl[i].lstb));
            chk($sformatf("v%0d_ldat", i),  64'(load_fifo_write_data),    64'(tbl[i].ldat));
            chk($sformatf("v%0d_sstb", i),  64'(store_fifo_write_signal), 64'(tbl[i].sstb));
            chk($sformatf("v%0d_sdat", i),  64'(store_fifo_write_data),   64'(tbl[i].sdat));
            chk($sformatf("v%0d_ready", i), 64'(req_ready),               64'(tbl[i].rdy));
            chk($sformatf("v%0d_count", i), 64'(outstanding_count),       64'(tbl[i].cnt));
            chk($sformatf("v%0d_mis", i),   64'(misaligned_error),        64'(tbl[i].mis));
            advance();
        end

        // Exhaust the tag pool with back-to-back loads.
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 12'(i * 4), 0, 2, 0, 0, 0, 0);
            settle();
            check_model();
            if (i > 0) chk("b2b_tag", 64'(load_fifo_write_data[5:2]), 64'(i - 1));
            advance();
        end
        drive(1, 0, 12'h200, 0, 2, 0, 0, 1, 4'd5);
        settle();
        check_model();
        chk("b2b_last_tag", 64'(load_fifo_write_data[5:2]), 15);
        chk("full_count",   64'(outstanding_count), 16);
        chk("full_ready",   64'(req_ready), 0);
        advance();
        drive(1, 0, 12'h040, 0, 2, 0, 0, 0, 0);
        settle();
        check_model();
        chk("retire_ready", 64'(req_ready), 1);
        chk("retire_count", 64'(outstanding_count), 15);
        advance();
        drive(1, 0, 12'h001, 0, 1, 0, 0, 0, 0);
        settle();
        check_model();
        chk("reuse_tag",  64'(load_fifo_write_data[5:2]), 5);
        chk("reuse_strb", 64'(load_fifo_write_signal), 1);
        advance();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        check_model();
        chk("nofree_mis", 64'(misaligned_error), 0);
        advance();

        // Reset while a word is pending.
        drive(0, 0, 0, 0, 0, 0, 0, 1, 4'd3);
        settle();
        check_model();
        advance();
        drive(1, 0, 12'h080, 0, 2, 0, 0, 0, 0);
        settle();
        check_model();
        advance();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        check_model();
        chk("pend_strb", 64'(load_fifo_write_signal), 1);
        reset = 1'b0;
        #1;
        model_reset();
        chk("midrst_lstb",  64'(load_fifo_write_signal),  0);
        chk("midrst_sstb",  64'(store_fifo_write_signal), 0);
        chk("midrst_ldat",  64'(load_fifo_write_data),    0);
        chk("midrst_count", 64'(outstanding_count),       0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(1, 0, 12'h0C0, 0, 2, 0, 0, 0, 0);
        settle();
        check_model();
        advance();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        check_model();
        chk("post_rst_tag",  64'(load_fifo_write_data[5:2]), 0);
        chk("post_rst_strb", 64'(load_fifo_write_signal), 1);
        advance();

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(9) < 7, $urandom_range(1), 12'($urandom), $urandom, 2'($urandom_range(3)),
                  $urandom_range(9) < 3, $urandom_range(9) < 3, $urandom_range(9) < 3, 4'($urandom_range(15)));
            settle();
            check_model();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
